// File: rtl/servant_arb_pkg.sv
// Shared types and constants for the servant RAM arbiter and its watchdog.
// State encodings are fixed so that they stay stable across debug dumps.
package servant_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    LAST_I = 1'b0,
    LAST_D = 1'b1
  } arb_master_t;

  localparam logic [31:0] RDT_ERR = 32'h0;
  localparam logic [3:0]  SEL_ALL = 4'hf;

endpackage

// File: rtl/servant_wb_watchdog.sv
// Grant-duration watchdog: counts cycles while enabled and flags the last allowed cycle.
// The counter is cleared in IDLE, so every grant starts counting from zero.
module servant_wb_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign hit = en & (cnt == LAST_CNT);

endmodule

// File: rtl/servant_ram_arbiter.sv
// Round-robin Wishbone arbiter sharing servant_ram between SERV ibus and dbus.
// IDLE is visited between grants; stalled grants are force-acked by a watchdog.
//
//   state | meaning
//   IDLE  | no grant, RAM outputs quiet, arbitration happens here
//   GNT_I | instruction bus owns the RAM (read-only)
//   GNT_D | data bus owns the RAM
module servant_ram_arbiter
  import servant_arb_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int aw      = 32
) (
  input  logic          i_wb_clk,
  input  logic          i_wb_rst,
  input  logic [aw-1:0] i_wb_ibus_adr,
  input  logic          i_wb_ibus_cyc,
  output logic [31:0]   o_wb_ibus_rdt,
  output logic          o_wb_ibus_ack,
  input  logic [aw-1:0] i_wb_dbus_adr,
  input  logic [31:0]   i_wb_dbus_dat,
  input  logic [3:0]    i_wb_dbus_sel,
  input  logic          i_wb_dbus_we,
  input  logic          i_wb_dbus_cyc,
  output logic [31:0]   o_wb_dbus_rdt,
  output logic          o_wb_dbus_ack,
  output logic [aw-1:0] o_wb_ram_adr,
  output logic [31:0]   o_wb_ram_dat,
  output logic [3:0]    o_wb_ram_sel,
  output logic          o_wb_ram_we,
  output logic          o_wb_ram_cyc,
  input  logic [31:0]   i_wb_ram_rdt,
  input  logic          i_wb_ram_ack,
  output logic          o_timeout
);

  arb_state_t  state_q, state_d;
  arb_master_t last_q, last_d;
  logic        granted;
  logic        gnt_cyc;
  logic        wd_hit;
  logic        timeout_set;
  logic [31:0] rdt_mux;

  assign granted = (state_q == GNT_I) || (state_q == GNT_D);

  servant_wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk (i_wb_clk),
    .rst (i_wb_rst),
    .clr (!granted),
    .en  (granted),
    .hit (wd_hit)
  );

  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      state_q   <= IDLE;
      last_q    <= LAST_D;
      o_timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      if (timeout_set) begin
        o_timeout <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    timeout_set  = 1'b0;
    gnt_cyc      = 1'b0;
    o_wb_ram_cyc = 1'b0;
    o_wb_ram_adr = '0;
    o_wb_ram_dat = '0;
    o_wb_ram_sel = '0;
    o_wb_ram_we  = 1'b0;

    case (state_q)
      IDLE: begin
        // ibus wins unless dbus also asks and ibus was the last winner
        if (i_wb_ibus_cyc && (!i_wb_dbus_cyc || last_q == LAST_D)) begin
          state_d = GNT_I;
          last_d  = LAST_I;
        end else if (i_wb_dbus_cyc) begin
          state_d = GNT_D;
          last_d  = LAST_D;
        end
      end
      GNT_I: begin
        gnt_cyc      = i_wb_ibus_cyc;
        o_wb_ram_cyc = i_wb_ibus_cyc;
        o_wb_ram_adr = i_wb_ibus_adr;
        o_wb_ram_sel = SEL_ALL;
      end
      GNT_D: begin
        gnt_cyc      = i_wb_dbus_cyc;
        o_wb_ram_cyc = i_wb_dbus_cyc;
        o_wb_ram_adr = i_wb_dbus_adr;
        o_wb_ram_dat = i_wb_dbus_dat;
        o_wb_ram_sel = i_wb_dbus_sel;
        o_wb_ram_we  = i_wb_dbus_we;
      end
      default: state_d = IDLE;
    endcase

    // A real RAM ack outranks a coinciding watchdog hit
    if (granted) begin
      if (i_wb_ram_ack) begin
        state_d = IDLE;
      end else if (wd_hit) begin
        state_d     = IDLE;
        timeout_set = 1'b1;
      end else if (!gnt_cyc) begin
        state_d = IDLE;
      end
    end
  end

  assign rdt_mux       = i_wb_ram_ack ? i_wb_ram_rdt : RDT_ERR;
  assign o_wb_ibus_rdt = rdt_mux;
  assign o_wb_dbus_rdt = rdt_mux;
  assign o_wb_ibus_ack = (state_q == GNT_I) & (i_wb_ram_ack | wd_hit);
  assign o_wb_dbus_ack = (state_q == GNT_D) & (i_wb_ram_ack | wd_hit);

endmodule

// File: tb/tb_servant_ram_arbiter.sv
// Bench for servant_ram_arbiter: behavioural RAM, transaction-level reference model
// checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_servant_ram_arbiter;

  localparam int TO = 4;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] ibus_adr;
  logic          ibus_cyc;
  logic [31:0]   ibus_rdt;
  logic          ibus_ack;
  logic [AW-1:0] dbus_adr;
  logic [31:0]   dbus_dat;
  logic [3:0]    dbus_sel;
  logic          dbus_we;
  logic          dbus_cyc;
  logic [31:0]   dbus_rdt;
  logic          dbus_ack;
  logic [AW-1:0] ram_adr;
  logic [31:0]   ram_dat;
  logic [3:0]    ram_sel;
  logic          ram_we;
  logic          ram_cyc;
  logic [31:0]   ram_rdt;
  logic          ram_ack;
  logic          timeout;
  logic          ram_ack_en;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  servant_ram_arbiter #(
    .TIMEOUT (TO),
    .aw      (AW)
  ) dut (
    .i_wb_clk      (clk),
    .i_wb_rst      (rst),
    .i_wb_ibus_adr (ibus_adr),
    .i_wb_ibus_cyc (ibus_cyc),
    .o_wb_ibus_rdt (ibus_rdt),
    .o_wb_ibus_ack (ibus_ack),
    .i_wb_dbus_adr (dbus_adr),
    .i_wb_dbus_dat (dbus_dat),
    .i_wb_dbus_sel (dbus_sel),
    .i_wb_dbus_we  (dbus_we),
    .i_wb_dbus_cyc (dbus_cyc),
    .o_wb_dbus_rdt (dbus_rdt),
    .o_wb_dbus_ack (dbus_ack),
    .o_wb_ram_adr  (ram_adr),
    .o_wb_ram_dat  (ram_dat),
    .o_wb_ram_sel  (ram_sel),
    .o_wb_ram_we   (ram_we),
    .o_wb_ram_cyc  (ram_cyc),
    .i_wb_ram_rdt  (ram_rdt),
    .i_wb_ram_ack  (ram_ack),
    .o_timeout     (timeout)
  );

  // servant_ram-like slave: registered ack pulse and registered read data
  logic [31:0] mem [0:63];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_ack <= 1'b0;
      ram_rdt <= 32'h0;
      for (int k = 0; k < 64; k++) mem[k] <= 32'h0;
      mem[1] <= 32'h00050513;
      mem[2] <= 32'h11223344;
    end else begin
      ram_ack <= ram_cyc & ~ram_ack & ram_ack_en;
      if (ram_cyc & ram_we)
        for (int b = 0; b < 4; b++)
          if (ram_sel[b]) mem[ram_adr[7:2]][8*b +: 8] <= ram_dat[8*b +: 8];
      ram_rdt <= mem[ram_adr[7:2]];
    end
  end

  // Reference model: who owns the RAM (0 none, 1 ibus, 2 dbus) and for how long
  int m_own, m_last, m_age;
  bit m_sticky;

  function automatic int pick(input bit ic, input bit dc, input int last);
    if (ic && dc) return 3 - last;
    if (ic) return 1;
    if (dc) return 2;
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_own <= 0; m_last <= 2; m_age <= 0; m_sticky <= 1'b0;
    end else if (m_own == 0) begin
      if (pick(ibus_cyc, dbus_cyc, m_last) != 0) begin
        m_own  <= pick(ibus_cyc, dbus_cyc, m_last);
        m_last <= pick(ibus_cyc, dbus_cyc, m_last);
      end
      m_age <= 0;
    end else begin
      if (ram_ack) m_own <= 0;
      else if (m_age == TO - 1) begin m_own <= 0; m_sticky <= 1'b1; end
      else if (!(m_own == 1 ? ibus_cyc : dbus_cyc)) m_own <= 0;
      m_age <= m_age + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait budget expired at %0t", nm, $time);
  endtask

  // Per-cycle comparison against the model
  logic          e_hit, e_cyc, e_we, e_iack, e_dack;
  logic [AW-1:0] e_adr;
  logic [31:0]   e_dat;
  logic [3:0]    e_sel;
  initial begin
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) continue;
      e_hit  = (m_own != 0) && (m_age == TO - 1);
      e_cyc  = (m_own == 1) ? ibus_cyc : (m_own == 2) ? dbus_cyc : 1'b0;
      e_adr  = (m_own == 1) ? ibus_adr : (m_own == 2) ? dbus_adr : '0;
      e_dat  = (m_own == 2) ? dbus_dat : 32'h0;
      e_sel  = (m_own == 1) ? 4'hf : (m_own == 2) ? dbus_sel : 4'h0;
      e_we   = (m_own == 2) ? dbus_we : 1'b0;
      e_iack = (m_own == 1) && (ram_ack || e_hit);
      e_dack = (m_own == 2) && (ram_ack || e_hit);
      chk("m_ram_cyc", ram_cyc, e_cyc);
      chk("m_ram_adr", ram_adr, e_adr);
      chk("m_ram_dat", ram_dat, e_dat);
      chk("m_ram_sel", ram_sel, e_sel);
      chk("m_ram_we", ram_we, e_we);
      chk("m_ibus_ack", ibus_ack, e_iack);
      chk("m_dbus_ack", dbus_ack, e_dack);
      chk("m_timeout", timeout, m_sticky);
      if (e_iack) chk("m_ibus_rdt", ibus_rdt, ram_ack ? ram_rdt : 32'h0);
      if (e_dack) chk("m_dbus_rdt", dbus_rdt, ram_ack ? ram_rdt : 32'h0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One master transaction; starts and ends just after a rising edge
  task automatic xfer(input bit use_d, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input bit we, output logic [31:0] rdt,
                      output int lat, output int we_cyc, output int acks);
    lat = -1; we_cyc = 0; acks = 0; rdt = 32'hdeadbeef;
    if (use_d) begin
      dbus_adr = adr; dbus_dat = dat; dbus_sel = sel; dbus_we = we; dbus_cyc = 1'b1;
    end else begin
      ibus_adr = adr; ibus_cyc = 1'b1;
    end
    for (int c = 0; c < 20 && lat < 0; c++) begin
      @(negedge clk);
      if (ram_we) we_cyc++;
      if (use_d ? dbus_ack : ibus_ack) begin
        lat = c; acks++;
        rdt = use_d ? dbus_rdt : ibus_rdt;
      end
      step();
    end
    ibus_cyc = 1'b0; dbus_cyc = 1'b0; dbus_we = 1'b0;
    @(negedge clk);
    if (ram_we) we_cyc++;
    if (use_d ? dbus_ack : ibus_ack) acks++;
    step();
    if (lat < 0) fail_now("xfer_ack_wait");
  endtask

  logic [31:0] rdt;
  int lat, we_cyc, acks;
  logic [3:0] order;
  int ack_at [4];
  int n_ack;
  int stray;

  initial begin
    rst = 1'b0; ram_ack_en = 1'b1;
    ibus_adr = '0; ibus_cyc = 1'b0;
    dbus_adr = '0; dbus_dat = '0; dbus_sel = '0; dbus_we = 1'b0; dbus_cyc = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    chk("reset_ram_cyc", ram_cyc, 1'b0);
    chk("reset_ibus_ack", ibus_ack, 1'b0);
    chk("reset_dbus_ack", dbus_ack, 1'b0);
    chk("reset_timeout", timeout, 1'b0);
    step();

    // ibus-only fetch of mem[1]
    xfer(1'b0, 32'd4, 32'h0, 4'h0, 1'b0, rdt, lat, we_cyc, acks);
    chk("ibus_rdt", rdt, 32'h00050513);
    chk("ibus_latency", lat, 2);
    chk("ibus_ack_width", acks, 1);

    // dbus byte write then read back
    xfer(1'b1, 32'd8, 32'h0000AB00, 4'b0010, 1'b1, rdt, lat, we_cyc, acks);
    chk("dwr_latency", lat, 2);
    chk("dwr_ack_width", acks, 1);
    chk("dwr_we_cycles", we_cyc, 2);
    xfer(1'b1, 32'd8, 32'h0, 4'hf, 1'b0, rdt, lat, we_cyc, acks);
    chk("drd_rdt", rdt, 32'h1122AB44);
    chk("drd_ack_width", acks, 1);
    chk("drd_we_cycles", we_cyc, 0);

    // both masters held high after a fresh reset
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    step();
    ibus_adr = 32'd4; dbus_adr = 32'd8; dbus_sel = 4'hf; dbus_we = 1'b0;
    ibus_cyc = 1'b1; dbus_cyc = 1'b1;
    order = 4'h0; n_ack = 0;
    for (int c = 0; c < 40 && n_ack < 4; c++) begin
      @(negedge clk);
      if (ibus_ack && dbus_ack) chk("both_acked", 2'b11, 2'b01);
      if (ibus_ack || dbus_ack) begin
        order[n_ack] = dbus_ack;
        ack_at[n_ack] = c;
        if (n_ack == 0) chk("rr_first_rdt", ibus_rdt, 32'h00050513);
        if (n_ack == 1) chk("rr_second_rdt", dbus_rdt, 32'h11223344);
        n_ack++;
      end
      step();
    end
    ibus_cyc = 1'b0; dbus_cyc = 1'b0;
    if (n_ack < 4) fail_now("rr_four_acks");
    else begin
      chk("rr_order", order, 4'b1010);
      chk("rr_first_ack", ack_at[0], 2);
      for (int i = 1; i < 4; i++) chk("rr_spacing", ack_at[i] - ack_at[i-1], 3);
    end
    repeat (2) step();

    // RAM never acks: watchdog forces a zero-data ack
    ram_ack_en = 1'b0;
    xfer(1'b1, 32'd8, 32'h0, 4'hf, 1'b0, rdt, lat, we_cyc, acks);
    ram_ack_en = 1'b1;
    chk("to_latency", lat, TO);
    chk("to_rdt", rdt, 32'h0);
    chk("to_flag", timeout, 1'b1);
    repeat (3) step();
    xfer(1'b0, 32'd4, 32'h0, 4'h0, 1'b0, rdt, lat, we_cyc, acks);
    chk("post_to_latency", lat, 2);
    chk("to_sticky", timeout, 1'b1);

    // abort in the first grant cycle, then re-request and reset mid-grant
    ibus_adr = 32'd4; ibus_cyc = 1'b1;
    step();
    ibus_cyc = 1'b0;
    @(negedge clk);
    stray = ibus_ack + dbus_ack;
    step();
    ibus_cyc = 1'b1;
    @(negedge clk);
    stray += ibus_ack + dbus_ack;
    chk("abort_stray_ack", stray, 0);
    chk("abort_idle", ram_cyc, 1'b0);
    @(posedge clk);
    #3;
    chk("regrant_cyc", ram_cyc, 1'b1);
    rst = 1'b1;
    #1;
    chk("arst_ram_cyc", ram_cyc, 1'b0);
    chk("arst_ibus_ack", ibus_ack, 1'b0);
    chk("arst_dbus_ack", dbus_ack, 1'b0);
    chk("arst_timeout", timeout, 1'b0);
    ibus_cyc = 1'b0;
    #2 rst = 1'b0;
    step();
    xfer(1'b0, 32'd4, 32'h0, 4'h0, 1'b0, rdt, lat, we_cyc, acks);
    chk("post_rst_rdt", rdt, 32'h00050513);
    chk("post_rst_latency", lat, 2);
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete by %0t", $time);
    $fatal(1, "bench stalled");
  end

endmodule
